key_event_filter: RTL and testbench
===================================

// Module: key_event_filter
// PURPOSE
//  Sits between key_pad (raw one-hot key_data) and the game logic (dot_matrix).
//  Debounces the scanned keypad, rejects multi-key/glitch patterns, emits exactly one
//  4-bit key code per physical press, queued in a small FIFO with valid/ready pop.
//  Runs on the board 25 MHz clock; the consumer pops at its own pace.
// PARAMETERS
//  DEBOUNCE_CYC  250000  stable cycles needed for press or release (10 ms @ 25 MHz); >=2
//  FIFO_DEPTH    4       event queue entries; power of two
//  NKEYS         12      width of key_data
// PORTS
//  clk           in   1      system clock, 25 MHz
//  rst           in   1      asynchronous reset, active-high
//  key_data      in   12     from key_pad, bit i = key i pressed, synchronous to clk
//  ev_valid      out  1      FIFO non-empty, ev_code valid
//  ev_code       out  4      head event code 0..11 (bit index of key); 12..15 never produced
//  ev_ready      in   1      consumer pops head when ev_valid && ev_ready
//  ev_overflow   out  1      sticky: a press was dropped because FIFO full
//  key_held      out  1      a debounced key is currently down
// BEHAVIOUR
//  Reset (async, any time): state IDLE, counter 0, FIFO emptied, all outputs 0. Queued
//   events are discarded; clearing rst starts cleanly from IDLE on the next edge.
//  Input: key_data registered once (k_q). "Candidate" = k_q exactly one-hot;
//   zero or multi-hot counts as no key.
//  FSM (code register cur, counter cnt, width clog2(DEBOUNCE_CYC)):
//   IDLE:     k_q one-hot -> cur<=index, cnt<=0, DEBOUNCE.
//   DEBOUNCE: k_q != onehot(cur) -> IDLE, cnt<=0. Else if cnt==DEBOUNCE_CYC-1 -> push cur,
//             PRESSED. Else cnt++.
//   PRESSED:  k_q != onehot(cur) -> cnt<=0, RELEASE. No auto-repeat: holding never re-pushes.
//   RELEASE:  k_q == onehot(cur) -> PRESSED (bounce, no new event). Else if
//             cnt==DEBOUNCE_CYC-1 -> IDLE. Else cnt++. A different key appearing here
//             counts as "released"; it is only accepted after return to IDLE.
//  key_held = state is PRESSED or RELEASE.
//  Latency: key_data stable one-hot from cycle 0 -> k_q cycle 1 -> DEBOUNCE cycle 2 ->
//   push evaluated cycle DEBOUNCE_CYC+1 -> ev_valid=1 at cycle DEBOUNCE_CYC+2.
//  FIFO: show-ahead; ev_code = head, ev_valid = !empty; ev_code holds its value while
//   ev_valid && !ev_ready. ev_code is 0 when empty.
//   Pop and push same cycle: both happen; when full, pop frees the slot and push accepted.
//   Push when full with no pop: event dropped, ev_overflow<=1 (stays until rst).
//   Push into empty: ev_valid rises next cycle (no same-cycle bypass).
//   Pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
// STRUCTURE
//  Shared package/header: key code constants (KEY_0..KEY_11, index order = key_pad bit
//   order), FSM state encoding (IDLE=0, DEBOUNCE=1, PRESSED=2, RELEASE=3).
//  One sub-module: key_event_fifo (depth/width parameters, push/pop, full/empty,
//   async active-high reset). Debounce FSM and input register stay in this module.
// TESTING (DEBOUNCE_CYC=4, FIFO_DEPTH=4 in bench)
//  Clean press: key_data=12'h004 from cyc 0, ev_ready=0 -> ev_valid=1, ev_code=2 at
//   cyc 6; key_held=1 from cyc 6; exactly one event while held 100 cycles.
//  Bounce: 12'h010 for 2 cycles, 0 for 1, 12'h010 stable -> single event code 4,
//   ev_valid at 6 cycles after last transition to stable.
//  Multi-key: key_data=12'h003 held 20 cycles -> no event, key_held=0.
//  Release bounce: held key drops to 0 for 2 cycles then returns -> no second event;
//   release 0 stable 4+ cycles -> key_held=0, next press of same key -> new event.
//  Overflow: 5 distinct presses with ev_ready=0 -> codes of first 4 queued in order,
//   ev_overflow=1; then ev_ready=1 pops 4 events in 4 cycles, ev_valid=0 after.
//  Full + simultaneous pop/push: FIFO full, ev_ready=1 on push cycle -> push accepted,
//   ev_overflow stays 0. Assert rst mid-DEBOUNCE with queued events -> all outputs 0.

Source files
------------

// File: rtl/key_event_filter_pkg.sv
// Shared constants for the keypad event filter: key codes and debounce FSM encoding.
package key_event_filter_pkg;

  localparam int NUM_KEYS = 12;
  localparam int CODE_W   = 4;

  // Key codes follow key_pad bit order: bit i of key_data is key code i.
  localparam logic [CODE_W-1:0] KEY_0  = 4'd0;
  localparam logic [CODE_W-1:0] KEY_1  = 4'd1;
  localparam logic [CODE_W-1:0] KEY_2  = 4'd2;
  localparam logic [CODE_W-1:0] KEY_3  = 4'd3;
  localparam logic [CODE_W-1:0] KEY_4  = 4'd4;
  localparam logic [CODE_W-1:0] KEY_5  = 4'd5;
  localparam logic [CODE_W-1:0] KEY_6  = 4'd6;
  localparam logic [CODE_W-1:0] KEY_7  = 4'd7;
  localparam logic [CODE_W-1:0] KEY_8  = 4'd8;
  localparam logic [CODE_W-1:0] KEY_9  = 4'd9;
  localparam logic [CODE_W-1:0] KEY_10 = 4'd10;
  localparam logic [CODE_W-1:0] KEY_11 = 4'd11;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

endpackage

// File: rtl/key_event_filter_if.sv
// Event pop channel between the filter (master) and the game logic (slave).
interface key_event_filter_if;
  import key_event_filter_pkg::*;

  logic              ev_valid;
  logic [CODE_W-1:0] ev_code;
  logic              ev_ready;
  logic              ev_overflow;

  modport master (output ev_valid, output ev_code, output ev_overflow, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_overflow, output ev_ready);

endinterface

// File: rtl/key_event_filter_fifo.sv
// Show-ahead event queue; a push into a full queue is dropped unless a pop frees
// a slot on the same edge, and any drop sets a sticky overflow flag.
module key_event_fifo
  import key_event_filter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CODE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, pop_en, push_en;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign valid   = !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are only observable through head when non-empty.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_en) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      if (push_en && !pop_en)      count <= count + CNT_W'(1);
      else if (pop_en && !push_en) count <= count - CNT_W'(1);
      if (push && !push_en) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/key_event_filter.sv
// Keypad debouncer: one queued key code per physical single-key press.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | no key down; waiting for a one-hot sample
//  DEBOUNCE | candidate key seen; counting stable samples before accepting
//  PRESSED  | press accepted and queued; holding never re-queues
//  RELEASE  | key gone; counting stable absence, return of the key is a bounce
module key_event_filter
  import key_event_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int FIFO_DEPTH   = 4,
  parameter int NKEYS        = NUM_KEYS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NKEYS-1:0]     key_data,
  output logic                 key_held,
  key_event_filter_if.master   ev
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [NKEYS-1:0]  k_q;
  logic [1:0]        state;
  logic [CODE_W-1:0] cur;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] k_idx;
  logic              k_onehot, k_is_cur, push;

  assign k_onehot = $onehot(k_q);
  assign k_is_cur = (k_q == (NKEYS'(1) << cur));
  assign push     = (state == ST_DEBOUNCE) && k_is_cur && (cnt == CNT_LAST);
  assign key_held = (state == ST_PRESSED) || (state == ST_RELEASE);

  // Bit index of the sampled key; only used when exactly one bit is set.
  always_comb begin
    k_idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (k_q[i]) k_idx = CODE_W'(i);
    end
  end

  // Single input register; key_data is already in the clk_sys domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) k_q <= '0;
    else     k_q <= key_data;
  end

  // Debounce FSM: press and release both need DEBOUNCE_CYC stable samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (k_onehot) begin
            cur   <= k_idx;
            cnt   <= '0;
            state <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!k_is_cur) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= ST_PRESSED;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!k_is_cur) begin
            cnt   <= '0;
            state <= ST_RELEASE;
          end
        end
        default: begin
          if (k_is_cur) begin
            state <= ST_PRESSED;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cur),
    .pop       (ev.ev_ready),
    .head      (ev.ev_code),
    .valid     (ev.ev_valid),
    .overflow  (ev.ev_overflow)
  );

endmodule

// File: tb/tb_key_event_filter.sv
// Bench for key_event_filter with a short debounce window and a 4-deep queue.
module tb_key_event_filter;

  localparam int DC    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] key_data = '0;
  logic        key_held;

  key_event_filter_if bus ();

  key_event_filter #(
    .DEBOUNCE_CYC (DC),
    .FIFO_DEPTH   (DEPTH),
    .NKEYS        (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_data (key_data),
    .key_held (key_held),
    .ev       (bus.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: key press/release tracking plus an event queue.
  logic [11:0] mk_q;
  int          held_key, cand, run, rel_run;
  int          mq[$];
  bit          m_ovf;

  task automatic model_reset();
    mk_q = '0; held_key = -1; cand = -1; run = 0; rel_run = -1;
    mq.delete(); m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic [11:0] kd, input bit rdy);
    logic [11:0] s;
    bit pushed, pop_now;
    int pcode;
    s = mk_q; pushed = 1'b0; pcode = 0;
    pop_now = rdy && (mq.size() > 0);
    if (held_key < 0) begin
      if (cand < 0) begin
        if ($countones(s) == 1) begin cand = $clog2(s); run = 0; end
      end else if (s != (12'd1 << cand)) begin
        cand = -1;
      end else if (run == DC - 1) begin
        pushed = 1'b1; pcode = cand; held_key = cand; cand = -1; rel_run = -1;
      end else begin
        run++;
      end
    end else begin
      if (s == (12'd1 << held_key)) rel_run = -1;
      else if (rel_run < 0)         rel_run = 0;
      else if (rel_run == DC - 1)   held_key = -1;
      else                          rel_run++;
    end
    if (pop_now) void'(mq.pop_front());
    if (pushed) begin
      if (mq.size() < DEPTH) mq.push_back(pcode);
      else m_ovf = 1'b1;
    end
    mk_q = kd;
  endtask

  task automatic check_out(input string name, input bit v, input logic [3:0] c,
                           input bit h, input bit o);
    vectors++;
    if ({bus.ev_valid, bus.ev_code, key_held, bus.ev_overflow} !== {v, c, h, o}) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b code=%0d held=%0b ovf=%0b, want valid=%0b code=%0d held=%0b ovf=%0b",
               name, bus.ev_valid, bus.ev_code, key_held, bus.ev_overflow, v, c, h, o);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] c;
    c = (mq.size() > 0) ? 4'(mq[0]) : 4'd0;
    check_out(name, mq.size() > 0, c, held_key >= 0, m_ovf);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(input logic [11:0] kd, input bit rdy);
    key_data = kd;
    bus.ev_ready = rdy;
    @(posedge clk);
    model_edge(kd, rdy);
    #1;
    check_model("model");
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    key_data = '0;
    bus.ev_ready = 1'b0;
    #1;
    check_out("rst_async", 1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic press(input int k);
    for (int i = 0; i < 6; i++) step(12'd1 << k, 1'b0);
    for (int i = 0; i < 6; i++) step(12'd0, 1'b0);
  endtask

  typedef struct {
    logic [11:0] kd;
    bit          rdy;
    int          n;
    bit          v;
    logic [3:0]  c;
    bit          h;
    bit          o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [11:0] kd, input bit rdy, input int n,
                     input bit v, input logic [3:0] c, input bit h, input bit o);
    vec_t r;
    r.kd = kd; r.rdy = rdy; r.n = n; r.v = v; r.c = c; r.h = h; r.o = o;
    tbl.push_back(r);
  endtask

  initial begin
    bus.ev_ready = 1'b0;
    model_reset();

    // Clean press, hold, pop, release.
    add(12'h004, 0, 5,   0, 0, 0, 0);
    add(12'h004, 0, 1,   1, 2, 1, 0);
    add(12'h004, 0, 100, 1, 2, 1, 0);
    add(12'h004, 1, 1,   0, 0, 1, 0);
    add(12'h000, 0, 5,   0, 0, 1, 0);
    add(12'h000, 0, 1,   0, 0, 0, 0);
    // Multi-key pattern rejected.
    add(12'h003, 0, 20,  0, 0, 0, 0);
    add(12'h000, 0, 2,   0, 0, 0, 0);
    // Press bounce.
    add(12'h010, 0, 2,   0, 0, 0, 0);
    add(12'h000, 0, 1,   0, 0, 0, 0);
    add(12'h010, 0, 5,   0, 0, 0, 0);
    add(12'h010, 0, 1,   1, 4, 1, 0);
    add(12'h010, 1, 1,   0, 0, 1, 0);
    // Release bounce, then clean release and a second press of the same key.
    add(12'h000, 0, 2,   0, 0, 1, 0);
    add(12'h010, 0, 10,  0, 0, 1, 0);
    add(12'h000, 0, 5,   0, 0, 1, 0);
    add(12'h000, 0, 1,   0, 0, 0, 0);
    add(12'h010, 0, 5,   0, 0, 0, 0);
    add(12'h010, 0, 1,   1, 4, 1, 0);
    add(12'h000, 1, 1,   0, 0, 1, 0);
    add(12'h000, 0, 5,   0, 0, 0, 0);
    // Five presses into a four-deep queue, then drain.
    add(12'h001, 0, 6,   1, 0, 1, 0);
    add(12'h000, 0, 6,   1, 0, 0, 0);
    add(12'h002, 0, 6,   1, 0, 1, 0);
    add(12'h000, 0, 6,   1, 0, 0, 0);
    add(12'h004, 0, 6,   1, 0, 1, 0);
    add(12'h000, 0, 6,   1, 0, 0, 0);
    add(12'h008, 0, 6,   1, 0, 1, 0);
    add(12'h000, 0, 6,   1, 0, 0, 0);
    add(12'h020, 0, 6,   1, 0, 1, 1);
    add(12'h000, 0, 6,   1, 0, 0, 1);
    add(12'h000, 1, 1,   1, 1, 0, 1);
    add(12'h000, 1, 1,   1, 2, 0, 1);
    add(12'h000, 1, 1,   1, 3, 0, 1);
    add(12'h000, 1, 1,   0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check_out("reset_state", 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      for (int i = 0; i < tbl[r].n; i++) step(tbl[r].kd, tbl[r].rdy);
      check_out($sformatf("row%0d", r), tbl[r].v, tbl[r].c, tbl[r].h, tbl[r].o);
    end

    // Full queue with a pop on the same edge as a new push: nothing dropped.
    do_reset();
    for (int k = 6; k < 10; k++) press(k);
    for (int i = 0; i < 5; i++) step(12'h400, 1'b0);
    step(12'h400, 1'b1);
    check_out("full_pop_push", 1'b1, 4'd7, 1'b1, 1'b0);
    for (int i = 8; i <= 10; i++) begin
      step(12'h000, 1'b1);
      check_out("drain", 1'b1, 4'(i), 1'b1, 1'b0);
    end
    step(12'h000, 1'b1);
    check_out("drain_empty", 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(12'h000, 1'b0);

    // Reset while debouncing with an event queued.
    press(11);
    for (int i = 0; i < 3; i++) step(12'h002, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(12'h000, 1'b0);

    // Randomized segments against the reference model.
    for (int seg = 0; seg < 500; seg++) begin
      logic [11:0] kd;
      int sel, len;
      sel = $urandom_range(0, 99);
      len = $urandom_range(1, 8);
      if (sel < 45)      kd = 12'h000;
      else if (sel < 85) kd = 12'd1 << $urandom_range(0, 11);
      else               kd = 12'($urandom);
      for (int i = 0; i < len; i++) step(kd, $urandom_range(0, 99) < 25);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
